i2c_controller: RTL and testbench
=================================

I2C_CONTROLLER -- requirements
Module: i2c_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, system clocks per SCL quarter-period (legal >= 2).
REQ-002 SHALL have ports: clk  in  1  system clock; reset  in  1  reset, synchronous, active-high; clock clk.
REQ-003 SHALL have ports: start  in  1  one-cycle request to begin a transaction; addr  in  7  target address; is_read  in  1  1 = read, 0 = write; num_bytes  in  8  data byte count (0 = address-only).
REQ-004 SHALL have ports: tx_data  in  8  next write byte; tx_take  out  1  one-cycle pulse when tx_data has been latched.
REQ-005 SHALL have ports: rx_data  out  8  received byte; rx_valid  out  1  one-cycle pulse when rx_data is new.
REQ-006 SHALL have ports: busy  out  1  transaction in progress; done  out  1  one-cycle pulse at end of transaction; nack  out  1  last transaction aborted on a missing ACK, held until the next start.
REQ-007 SHALL have ports: scl_o  out  1  SCL drive value, always driven, with no clock stretching support; sda_i  in  1  SDA bus level; sda_o  out  1  SDA drive value; sda_e  out  1  SDA drive enable (0 = released to pull-up).

Function
REQ-008 SHALL time SCL using a quarter counter of CLK_DIV clocks, with each bit taking 4 quarters: Q0-Q1 SCL low, Q2-Q3 SCL high.
REQ-009 SHALL change SDA only at the start of Q0 of a bit, and SHALL sample sda_i on the last clock of Q2.
REQ-010 SHALL implement states IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP.
REQ-011 IDLE: scl_o=1, sda_e=0, busy=0. start latches addr, is_read and num_bytes, sets busy=1, clears nack, and enters START on the next clock.
REQ-012 SHALL ignore start while busy=1.
REQ-013 START: SDA released (high) for 2 quarters, then SDA driven 0 for 2 quarters with SCL high, then enters ADDR with SCL low.
REQ-014 ADDR: SHALL shift out {addr, is_read} MSB first over 8 bits with sda_e=1.
REQ-015 ADDR_ACK: sda_e=0 for 1 bit, with the sample taken per REQ-009.
  - sample=1 -> nack=1, go to STOP.
  - sample=0 and num_bytes=0 -> go to STOP.
  - sample=0, otherwise -> go to WRITE or READ per is_read.
REQ-016 WRITE: tx_data SHALL be latched and tx_take pulsed exactly once per byte, in the cycle the byte's first bit begins.
  - The byte is shifted MSB first.
  - Then go to WRITE_ACK, which uses the same sampling as ADDR_ACK.
  - NACK -> nack=1, go to STOP.
  - ACK with bytes remaining -> go to WRITE.
  - ACK on the last byte -> go to STOP.
REQ-017 READ: sda_e=0; 8 sampled bits SHALL be shifted in MSB first.
  - rx_data is updated and rx_valid pulsed on the clock after the 8th sample.
REQ-018 READ_ACK: the controller SHALL drive SDA 0 (ACK) if bytes remain, or release SDA (NACK) after the last byte.
  - Then go to READ or STOP accordingly.
  - A read never sets nack.
REQ-019 STOP: one bit with SDA driven 0, SCL rising at Q2, then SDA released at the end of Q3 while SCL is high.
  - Followed by one further quarter of bus idle.
  - Then done pulses for 1 cycle, busy=0, and the state returns to IDLE.
REQ-020 SHALL hold an internal byte counter of 8 bits, decremented per completed data byte.
  - The counter SHALL never wrap; num_bytes=255 yields exactly 255 bytes.
REQ-021 SHALL allow the bus to be observed with no START/STOP glitches: SDA never changes while SCL is high except in START and STOP.

Reset
REQ-022 When reset=1, on the next clk edge the block SHALL set state=IDLE, scl_o=1, sda_o=1, sda_e=0, busy=0, done=0, nack=0, tx_take=0, rx_valid=0, rx_data=0, and clear all counters.
REQ-023 Reset mid-transaction SHALL abandon the transaction without emitting STOP or done; the first start after reset SHALL behave normally.

Verification
REQ-024 Write with an ACKing target at 0x55: addr=0x55, is_read=0, num_bytes=2, tx_data 0xA5 then 0x3C.
  - Bus shows START, 0xAA, ACK, 0xA5, ACK, 0x3C, ACK, STOP.
  - 2 tx_take pulses, 1 done pulse, nack=0.
REQ-025 Absent address: addr=0x22 with no target answering.
  - Bus shows START, 0x44, NACK, STOP.
  - done pulses, nack=1, zero tx_take pulses.
REQ-026 Read with a target returning 0x03 then 0x06: addr=0x55, is_read=1, num_bytes=2.
  - Bus shows 0xAB, then controller ACK after byte 1 and NACK after byte 2.
  - rx_valid pulses with rx_data=0x03 then 0x06.
REQ-027 Address-only: num_bytes=0, addr=0x55.
  - Bus shows START, 0xAA, ACK, STOP.
  - done pulses, with no tx_take or rx_valid pulses.
REQ-028 Start while busy: a second start pulse during byte 1 of REQ-024 SHALL have no effect, and exactly one done SHALL occur.
REQ-029 Reset mid-transaction: reset asserted during WRITE bit 3.
  - Next cycle scl_o=1, sda_e=0, busy=0.
  - A following REQ-024 transaction passes.

Source files
------------

// File: rtl/i2c_controller.sv
// ---------------------------------------------------------------------------
// i2c_controller
//
// Single-master I2C controller. Each bus bit is four quarters of CLK_DIV
// system clocks: SCL is low in Q0-Q1 and high in Q2-Q3. The controller
// changes SDA only when a new bit begins (start of Q0). It samples SDA on
// the last clock of Q2. The only exceptions are the START and STOP
// conditions, which move SDA while SCL is high. There is no clock
// stretching, so SCL is always driven.
//
// Parameters
//   CLK_DIV    system clocks per SCL quarter-period (>= 2)
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   start      one-cycle request to begin a transaction (ignored while busy)
//   addr       7-bit target address
//   is_read    1 = read transaction, 0 = write transaction
//   num_bytes  data byte count, 0 = address-only probe
//   tx_data    next byte to write; latched when tx_take pulses
//   tx_take    one-cycle pulse in the cycle a write byte's first bit begins
//   rx_data    last received byte
//   rx_valid   one-cycle pulse when rx_data is new
//   busy       transaction in progress
//   done       one-cycle pulse at the end of a transaction
//   nack       last transaction aborted on a missing ACK; held until next start
//   scl_o      SCL drive value
//   sda_i      SDA bus level
//   sda_o      SDA drive value
//   sda_e      SDA drive enable (0 = released to the pull-up)
// ---------------------------------------------------------------------------
`timescale 1ns / 1ps

module i2c_controller #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       is_read,
    input  logic [7:0] num_bytes,
    input  logic [7:0] tx_data,
    output logic       tx_take,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       scl_o,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_e
);

    localparam int              QW     = $clog2(CLK_DIV);
    localparam logic [QW-1:0]   Q_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        STOP
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    // Bit timing
    logic [QW-1:0]   r_qcnt;        // clock within the current quarter
    logic [2:0]      r_quarter;     // quarter within the current bit (STOP uses 0..4)
    logic [2:0]      r_bit;         // bit index within a byte
    logic [2:0]      w_quarter_last;
    logic            w_q_end;
    logic            w_bit_end;
    logic            w_sample_tick;
    logic            w_scl_high;

    // Transaction datapath
    logic [7:0]      r_shift;       // outgoing byte (MSB on the bus) or incoming byte
    logic [7:0]      r_count;       // data bytes still to transfer
    logic            r_rd;
    logic            r_sample;      // SDA level taken on the last clock of Q2
    logic            r_rx_pend;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid;
    logic            r_tx_take;
    logic            r_done;
    logic            r_nack;
    logic            w_more;

    // Bus drive decode
    logic            w_scl;
    logic            w_sda_o;
    logic            w_sda_e;
    logic            w_busy;

    // The STOP bit carries a fifth quarter of bus idle after SDA is released.
    assign w_quarter_last = (r_state == STOP) ? 3'd4 : 3'd3;
    assign w_q_end        = (r_qcnt == Q_LAST);
    assign w_bit_end      = w_q_end && (r_quarter == w_quarter_last);
    assign w_sample_tick  = w_q_end && (r_quarter == 3'd2);
    assign w_scl_high     = (r_quarter >= 3'd2);
    assign w_more         = (r_count != 8'd0);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            // NOTE: state is updated with <= so every flop samples the
            // pre-edge values of its neighbours, exactly like the hardware.
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and bus drive
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: everything this block writes gets a default first, so no
        // branch can leave a value unassigned and infer a latch.
        w_next_state = r_state;
        w_scl        = w_scl_high;
        w_sda_o      = 1'b1;
        w_sda_e      = 1'b0;
        w_busy       = 1'b1;

        case (r_state)
            IDLE: begin
                w_scl  = 1'b1;
                w_busy = 1'b0;
                if (start) begin
                    w_next_state = START;
                end
            end

            START: begin
                // SCL stays high the whole bit; SDA falls halfway through.
                w_scl = 1'b1;
                if (r_quarter >= 3'd2) begin
                    w_sda_e = 1'b1;
                    w_sda_o = 1'b0;
                end
                if (w_bit_end) begin
                    w_next_state = ADDR;
                end
            end

            ADDR: begin
                w_sda_e = 1'b1;
                w_sda_o = r_shift[7];
                if (w_bit_end && (r_bit == 3'd7)) begin
                    w_next_state = ADDR_ACK;
                end
            end

            ADDR_ACK: begin
                if (w_bit_end) begin
                    if (r_sample || !w_more) begin
                        w_next_state = STOP;
                    end else if (r_rd) begin
                        w_next_state = READ;
                    end else begin
                        w_next_state = WRITE;
                    end
                end
            end

            WRITE: begin
                w_sda_e = 1'b1;
                w_sda_o = r_shift[7];
                if (w_bit_end && (r_bit == 3'd7)) begin
                    w_next_state = WRITE_ACK;
                end
            end

            WRITE_ACK: begin
                if (w_bit_end) begin
                    w_next_state = (!r_sample && w_more) ? WRITE : STOP;
                end
            end

            READ: begin
                if (w_bit_end && (r_bit == 3'd7)) begin
                    w_next_state = READ_ACK;
                end
            end

            READ_ACK: begin
                // The counter was already decremented for this byte, so a
                // non-zero count means another byte follows: ACK it.
                if (w_more) begin
                    w_sda_e = 1'b1;
                    w_sda_o = 1'b0;
                end
                if (w_bit_end) begin
                    w_next_state = w_more ? READ : STOP;
                end
            end

            STOP: begin
                // SDA held low through Q0-Q3, released for the idle quarter.
                if (r_quarter != 3'd4) begin
                    w_sda_e = 1'b1;
                    w_sda_o = 1'b0;
                end
                if (w_bit_end) begin
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Bit timing and datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every register here is cleared on reset (not only the
            // control state) so a transaction cut short leaves no stale
            // byte, count or pulse behind.
            r_qcnt     <= '0;
            r_quarter  <= 3'd0;
            r_bit      <= 3'd0;
            r_shift    <= 8'd0;
            r_count    <= 8'd0;
            r_rd       <= 1'b0;
            r_sample   <= 1'b0;
            r_rx_pend  <= 1'b0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_tx_take  <= 1'b0;
            r_done     <= 1'b0;
            r_nack     <= 1'b0;
        end else begin
            r_tx_take  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_done     <= 1'b0;

            // Quarter counter runs only while a transaction is active.
            if (r_state == IDLE) begin
                r_qcnt    <= '0;
                r_quarter <= 3'd0;
            end else if (w_q_end) begin
                r_qcnt    <= '0;
                r_quarter <= w_bit_end ? 3'd0 : r_quarter + 3'd1;
            end else begin
                r_qcnt <= r_qcnt + QW'(1);
            end

            if ((r_state == IDLE) && start) begin
                r_shift <= {addr, is_read};
                r_rd    <= is_read;
                r_count <= num_bytes;
                r_nack  <= 1'b0;
            end

            // A received byte is published one clock after its 8th sample.
            if (r_rx_pend) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                r_rx_pend  <= 1'b0;
            end

            if (w_sample_tick) begin
                r_sample <= sda_i;
                if (r_state == READ) begin
                    r_shift   <= {r_shift[6:0], sda_i};
                    r_rx_pend <= (r_bit == 3'd7);
                end
            end

            if (w_bit_end) begin
                r_bit <= (w_next_state == r_state) ? r_bit + 3'd1 : 3'd0;

                if ((w_next_state == WRITE) && (r_state != WRITE)) begin
                    // First bit of a new write byte begins this cycle.
                    r_shift   <= tx_data;
                    r_tx_take <= 1'b1;
                end else if ((r_state == ADDR) || (r_state == WRITE)) begin
                    r_shift <= {r_shift[6:0], 1'b0};
                end

                if (((r_state == WRITE) || (r_state == READ)) &&
                    (r_bit == 3'd7) && w_more) begin
                    r_count <= r_count - 8'd1;
                end

                if (((r_state == ADDR_ACK) || (r_state == WRITE_ACK)) && r_sample) begin
                    r_nack <= 1'b1;
                end

                if (r_state == STOP) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign scl_o    = w_scl;
    assign sda_o    = w_sda_o;
    assign sda_e    = w_sda_e;
    assign busy     = w_busy;
    assign tx_take  = r_tx_take;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign done     = r_done;
    assign nack     = r_nack;

endmodule

// File: tb/tb_i2c_controller.sv
// ---------------------------------------------------------------------------
// tb_i2c_controller
//
// Drives i2c_controller against a behavioural I2C target on a wired-AND SDA
// line. A bus monitor turns SCL/SDA activity into a token stream (START,
// bytes, ACK/NACK, STOP). For each transaction, a transaction-level model
// built from the I2C protocol predicts that stream, the nack flag, the
// tx_take count and the received bytes.
// ---------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_i2c_controller;

    localparam int CLK_DIV  = 3;
    localparam int BIT_CYC  = 4 * CLK_DIV;
    localparam int TOK_ACK  = 256;
    localparam int TOK_NACK = 257;
    localparam int TOK_S    = 512;
    localparam int TOK_P    = 513;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       start     = 1'b0;
    logic [6:0] addr      = 7'd0;
    logic       is_read   = 1'b0;
    logic [7:0] num_bytes = 8'd0;
    logic [7:0] tx_data;
    logic       tx_take;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       nack;
    logic       scl_o;
    logic       sda_o;
    logic       sda_e;
    logic       t_low = 1'b0;     // target pulling SDA low
    logic       w_sda;

    assign w_sda = (sda_e ? sda_o : 1'b1) & ~t_low;

    always #5 clk = ~clk;

    i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .addr      (addr),
        .is_read   (is_read),
        .num_bytes (num_bytes),
        .tx_data   (tx_data),
        .tx_take   (tx_take),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .done      (done),
        .nack      (nack),
        .scl_o     (scl_o),
        .sda_i     (w_sda),
        .sda_o     (sda_o),
        .sda_e     (sda_e)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Environment state
    logic [7:0] tx_mem [256];
    logic [7:0] rd_mem [256];
    logic [6:0] tgt_addr    = 7'h55;
    bit         tgt_present = 1'b1;
    int         tgt_nack_at = 0;        // write data frame the target refuses (0 = none)
    int         n_take      = 0;
    int         n_done      = 0;
    int         take_base   = 0;
    int         rx_q  [$];
    int         mon_q [$];

    assign tx_data = tx_mem[8'(n_take - take_base)];

    // Bus monitor and target, sampled away from the DUT's clock edge
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         pos      = 0;
    int         frame    = 0;
    logic [7:0] sh       = 8'd0;
    logic       t_active = 1'b0;
    logic       t_rd     = 1'b0;
    logic       t_match  = 1'b0;

    always @(negedge clk) begin
        if (prev_scl && scl_o && prev_sda && !w_sda) begin
            mon_q.push_back(TOK_S);
            t_active = 1'b1;
            pos      = 0;
            frame    = 0;
            t_low    = 1'b0;
        end else if (prev_scl && scl_o && !prev_sda && w_sda) begin
            mon_q.push_back(TOK_P);
            t_active = 1'b0;
            t_low    = 1'b0;
        end else if (!prev_scl && scl_o) begin
            pos++;
            if (pos <= 8) sh = {sh[6:0], w_sda};
            if (pos == 8) begin
                mon_q.push_back(int'(sh));
                if (frame == 0) begin
                    t_rd    = w_sda;
                    t_match = tgt_present && (sh[7:1] == tgt_addr);
                end
            end
            if (pos == 9) begin
                mon_q.push_back(w_sda ? TOK_NACK : TOK_ACK);
                if (w_sda) t_active = 1'b0;
            end
        end else if (prev_scl && !scl_o) begin
            if (pos >= 9) begin
                pos = 0;
                frame++;
            end
            t_low = 1'b0;
            if (t_active) begin
                if (pos == 8)
                    t_low = (frame == 0) ? t_match : (!t_rd && (frame != tgt_nack_at));
                else if ((frame > 0) && t_rd)
                    t_low = ~rd_mem[8'(frame - 1)][3'(7 - pos)];
            end
        end
        prev_scl = scl_o;
        prev_sda = w_sda;
        if (tx_take)  n_take++;
        if (rx_valid) rx_q.push_back(int'(rx_data));
        if (done)     n_done++;
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // One transaction: predict, run, compare.
    task automatic run_txn(input logic [6:0] a, input logic rd, input int n,
                           input int nack_at, input bit busy_start);
        int exp_q [$];
        int rx_exp [$];
        int exp_take;
        int exp_nack;
        int mb, tb0, rb, db, cyc, budget, len;
        bit acked;

        acked    = tgt_present && (a == tgt_addr);
        exp_take = 0;
        exp_nack = acked ? 0 : 1;
        exp_q.push_back(TOK_S);
        exp_q.push_back(int'({a, rd}));
        exp_q.push_back(acked ? TOK_ACK : TOK_NACK);
        if (acked) begin
            for (int i = 0; i < n; i++) begin
                if (rd) begin
                    exp_q.push_back(int'(rd_mem[i]));
                    exp_q.push_back((i == n - 1) ? TOK_NACK : TOK_ACK);
                    rx_exp.push_back(int'(rd_mem[i]));
                end else begin
                    exp_take++;
                    exp_q.push_back(int'(tx_mem[i]));
                    if (i + 1 == nack_at) begin
                        exp_q.push_back(TOK_NACK);
                        exp_nack = 1;
                        break;
                    end
                    exp_q.push_back(TOK_ACK);
                end
            end
        end
        exp_q.push_back(TOK_P);

        tgt_nack_at = nack_at;
        take_base   = n_take;
        mb          = mon_q.size();
        tb0         = n_take;
        rb          = rx_q.size();
        db          = n_done;
        addr        = a;
        is_read     = rd;
        num_bytes   = 8'(n);
        pulse_start();
        check("busy_after_start", 32'(busy), 1);

        budget = (9 * (n + 1) + 4) * BIT_CYC + 50;
        cyc    = 0;
        while ((n_done == db) && (cyc < budget)) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy_start) begin
                start = (cyc == 12 * BIT_CYC);
                if (start) begin
                    addr      = ~a;
                    is_read   = ~rd;
                    num_bytes = 8'd5;
                end
            end
        end
        start = 1'b0;
        check("done_in_time", 32'(cyc < budget), 1);
        repeat (2 * BIT_CYC) @(posedge clk);
        #1;
        check("done_count", 32'(n_done - db), 1);
        check("busy_idle", 32'(busy), 0);
        check("scl_idle", 32'(scl_o), 1);
        check("sda_e_idle", 32'(sda_e), 0);
        check("nack_flag", 32'(nack), 32'(exp_nack));
        check("tx_take_count", 32'(n_take - tb0), 32'(exp_take));
        check("rx_count", 32'(rx_q.size() - rb), 32'(rx_exp.size()));
        len = (rx_q.size() - rb < rx_exp.size()) ? rx_q.size() - rb : rx_exp.size();
        for (int i = 0; i < len; i++) check("rx_data", 32'(rx_q[rb + i]), 32'(rx_exp[i]));
        check("bus_tokens", 32'(mon_q.size() - mb), 32'(exp_q.size()));
        len = (mon_q.size() - mb < exp_q.size()) ? mon_q.size() - mb : exp_q.size();
        for (int i = 0; i < len; i++) check("bus_token", 32'(mon_q[mb + i]), 32'(exp_q[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int cyc, tb0, db0;
        logic [6:0] a;
        logic       rd;
        int         n, na;

        for (int i = 0; i < 256; i++) begin
            tx_mem[i] = 8'($urandom);
            rd_mem[i] = 8'($urandom);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", 32'(scl_o), 1);
        check("rst_sda_o", 32'(sda_o), 1);
        check("rst_sda_e", 32'(sda_e), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_nack", 32'(nack), 0);
        check("rst_tx_take", 32'(tx_take), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        reset = 1'b0;
        repeat (4) @(posedge clk);

        // Two-byte write to an ACKing target
        tgt_addr  = 7'h55;
        tx_mem[0] = 8'hA5;
        tx_mem[1] = 8'h3C;
        run_txn(7'h55, 1'b0, 2, 0, 1'b0);

        // Absent address
        run_txn(7'h22, 1'b0, 2, 0, 1'b0);

        // Two-byte read
        rd_mem[0] = 8'h03;
        rd_mem[1] = 8'h06;
        run_txn(7'h55, 1'b1, 2, 0, 1'b0);

        // Address-only probe
        run_txn(7'h55, 1'b0, 0, 0, 1'b0);

        // Start request while busy
        run_txn(7'h55, 1'b0, 2, 0, 1'b1);

        // Reset during bit 3 of the first write byte
        take_base = n_take;
        tb0       = n_take;
        db0       = n_done;
        addr      = 7'h55;
        is_read   = 1'b0;
        num_bytes = 8'd2;
        pulse_start();
        cyc = 0;
        while ((n_take == tb0) && (cyc < 40 * BIT_CYC)) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rst_mid_reached_write", 32'(n_take - tb0), 1);
        repeat (3 * BIT_CYC + BIT_CYC / 2 - 1) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_scl", 32'(scl_o), 1);
        check("rst_mid_sda_e", 32'(sda_e), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_rx_data", 32'(rx_data), 0);
        reset = 1'b0;
        repeat (3 * BIT_CYC) @(posedge clk);
        #1;
        check("rst_mid_no_done", 32'(n_done - db0), 0);
        run_txn(7'h55, 1'b0, 2, 0, 1'b0);

        // Longest write: the byte counter must not wrap
        for (int i = 0; i < 256; i++) tx_mem[i] = 8'($urandom);
        run_txn(7'h55, 1'b0, 255, 0, 1'b0);

        // Randomized transactions
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 8; i++) begin
                tx_mem[i] = 8'($urandom);
                rd_mem[i] = 8'($urandom);
            end
            tgt_addr = 7'($urandom);
            a        = tgt_addr;
            if ($urandom_range(0, 3) == 0) a = tgt_addr ^ 7'($urandom_range(1, 127));
            n  = $urandom_range(0, 4);
            rd = (n == 0) ? 1'b0 : 1'($urandom);
            na = 0;
            if (!rd && (n > 0) && ($urandom_range(0, 3) == 0)) na = $urandom_range(1, n);
            run_txn(a, rd, n, na, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
